// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event path.
// The AMIGA_KEYMAP_EN build also uses KEY_NONE to mark unmapped codes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_e;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FC = 8'hFC;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    // Event word layout: {ext, brk, code[7:0]}
    localparam int EV_EXT_BIT = 9;
    localparam int EV_BRK_BIT = 8;
    localparam int EV_W       = 10;

    // Pause sends E1 followed by seven more bytes; it is reported as ext 0x77.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    localparam logic [6:0] KEY_NONE = 7'h7F;

endpackage

// File: rtl/ps2_amiga_keymap.sv
// Combinational {ext, set-2 code} -> Amiga raw keycode ROM; 7F means "no key".
// Only instantiated when AMIGA_KEYMAP_EN is defined.
module ps2_amiga_keymap
    import ps2_pkg::*;
(
    input  logic [8:0] key_i,
    output logic [6:0] amiga_o
);

    always_comb begin
        amiga_o = KEY_NONE;
        case (key_i)
            9'h01C: amiga_o = 7'h20;  9'h01B: amiga_o = 7'h21;  9'h023: amiga_o = 7'h22;
            9'h02B: amiga_o = 7'h23;  9'h034: amiga_o = 7'h24;  9'h033: amiga_o = 7'h25;
            9'h03B: amiga_o = 7'h26;  9'h042: amiga_o = 7'h27;  9'h04B: amiga_o = 7'h28;
            9'h015: amiga_o = 7'h10;  9'h01D: amiga_o = 7'h11;  9'h024: amiga_o = 7'h12;
            9'h02D: amiga_o = 7'h13;  9'h02C: amiga_o = 7'h14;  9'h035: amiga_o = 7'h15;
            9'h03C: amiga_o = 7'h16;  9'h043: amiga_o = 7'h17;  9'h044: amiga_o = 7'h18;
            9'h04D: amiga_o = 7'h19;  9'h01A: amiga_o = 7'h31;  9'h022: amiga_o = 7'h32;
            9'h021: amiga_o = 7'h33;  9'h02A: amiga_o = 7'h34;  9'h032: amiga_o = 7'h35;
            9'h031: amiga_o = 7'h36;  9'h03A: amiga_o = 7'h37;
            9'h016: amiga_o = 7'h01;  9'h01E: amiga_o = 7'h02;  9'h026: amiga_o = 7'h03;
            9'h025: amiga_o = 7'h04;  9'h02E: amiga_o = 7'h05;  9'h036: amiga_o = 7'h06;
            9'h03D: amiga_o = 7'h07;  9'h03E: amiga_o = 7'h08;  9'h046: amiga_o = 7'h09;
            9'h045: amiga_o = 7'h0A;
            9'h029: amiga_o = 7'h40;  9'h066: amiga_o = 7'h41;  9'h00D: amiga_o = 7'h42;
            9'h05A: amiga_o = 7'h44;  9'h076: amiga_o = 7'h45;  9'h075: amiga_o = 7'h3E;
            9'h012: amiga_o = 7'h60;  9'h059: amiga_o = 7'h61;  9'h058: amiga_o = 7'h62;
            9'h014: amiga_o = 7'h63;  9'h011: amiga_o = 7'h64;
            9'h005: amiga_o = 7'h50;  9'h006: amiga_o = 7'h51;  9'h004: amiga_o = 7'h52;
            9'h00C: amiga_o = 7'h53;  9'h003: amiga_o = 7'h54;  9'h00B: amiga_o = 7'h55;
            9'h083: amiga_o = 7'h56;  9'h00A: amiga_o = 7'h57;  9'h001: amiga_o = 7'h58;
            9'h009: amiga_o = 7'h59;
            // Extended (E0-prefixed) keys
            9'h175: amiga_o = 7'h4C;  9'h172: amiga_o = 7'h4D;  9'h174: amiga_o = 7'h4E;
            9'h16B: amiga_o = 7'h4F;  9'h111: amiga_o = 7'h65;  9'h11F: amiga_o = 7'h66;
            9'h127: amiga_o = 7'h67;  9'h171: amiga_o = 7'h46;  9'h15A: amiga_o = 7'h43;
            default: amiga_o = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 set-2 byte sequencer: prefix FSM, status flags, timeout and show-ahead event FIFO.
// Define AMIGA_KEYMAP_EN to emit Amiga raw keycodes instead of raw set-2 events.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [9:0]  ev_data_o,
    output logic        ev_valid_o,
    input  logic        ev_ready_i,
    output logic        bat_ok_o,
    output logic        kbd_err_o,
    output logic        timeout_o,
    output logic        overflow_o,
    input  logic        clr_i
);

    localparam int             CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam int             DEPTH    = 1 << FIFO_AW;

    ps2_state_e         state_q, state_d;
    logic [2:0]         skip_q, skip_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               push_q, push_d;
    logic [EV_W-1:0]    push_data_q, push_data_d;
    logic               bat_ok_q, bat_ok_d;
    logic               kbd_err_q, kbd_err_d;
    logic               timeout_q, timeout_d;
    logic               overflow_q, overflow_d;

    logic               raw_push, raw_ext, raw_brk;
    logic [7:0]         raw_code;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        cnt_d     = cnt_q;
        raw_push  = 1'b0;
        raw_ext   = 1'b0;
        raw_brk   = 1'b0;
        raw_code  = rx_data_i;
        bat_ok_d  = clr_i ? 1'b0 : bat_ok_q;
        kbd_err_d = 1'b0;
        timeout_d = 1'b0;
        if (rx_valid_i) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    case (rx_data_i)
                        BYTE_E0: state_d = ST_EXT;
                        BYTE_F0: state_d = ST_BRK;
                        BYTE_E1: begin
                            state_d = ST_PAUSE;
                            skip_d  = PAUSE_SKIP;
                        end
                        BYTE_AA: bat_ok_d = 1'b1;
                        BYTE_FC: begin
                            bat_ok_d  = 1'b0;
                            kbd_err_d = 1'b1;
                        end
                        BYTE_00, BYTE_FF: kbd_err_d = 1'b1;
                        BYTE_FA, BYTE_EE, BYTE_FE: ;
                        default: raw_push = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (rx_data_i == BYTE_F0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        raw_push = 1'b1;
                        raw_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    raw_push = 1'b1;
                    raw_brk  = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    raw_push = 1'b1;
                    raw_ext  = 1'b1;
                    raw_brk  = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        raw_push = 1'b1;
                        raw_ext  = 1'b1;
                        raw_code = PAUSE_CODE;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix sequence is abandoned without emitting anything.
            if (cnt_q == CNT_LAST) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef AMIGA_KEYMAP_EN
    logic [6:0] amiga_code;

    ps2_amiga_keymap u_keymap (
        .key_i   ({raw_ext, raw_code}),
        .amiga_o (amiga_code)
    );

    assign push_d      = raw_push && (amiga_code != KEY_NONE);
    assign push_data_d = {2'b00, raw_brk, amiga_code};
`else
    assign push_d      = raw_push;
    assign push_data_d = {raw_ext, raw_brk, raw_code};
`endif

    // Event FIFO; pointers carry an extra wrap bit to tell full from empty.
    logic [EV_W-1:0]    mem_q [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
    logic               fifo_empty, fifo_full, fifo_pop, fifo_wr;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign fifo_pop   = ev_ready_i && !fifo_empty;
    assign fifo_wr    = push_q && (!fifo_full || fifo_pop);

    always_comb begin
        overflow_d = clr_i ? 1'b0 : overflow_q;
        if (push_q && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            skip_q      <= '0;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            bat_ok_q    <= 1'b0;
            kbd_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            bat_ok_q    <= bat_ok_d;
            kbd_err_q   <= kbd_err_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign ev_valid_o = !fifo_empty;
    assign ev_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign bat_ok_o   = bat_ok_q;
    assign kbd_err_o  = kbd_err_q;
    assign timeout_o  = timeout_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl; expectations follow AMIGA_KEYMAP_EN when defined.
module tb_ps2_key_event_ctrl;

    localparam int TMO = 64;

`ifdef AMIGA_KEYMAP_EN
    localparam logic [9:0] EXP_1C    = 10'h020;
    localparam logic [9:0] EXP_UPBRK = 10'h0CC;
    localparam logic [9:0] EXP_76    = 10'h045;
    localparam logic [9:0] EXP_75    = 10'h03E;
    localparam logic [9:0] EXP_OVF [9] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014,
                                           10'h015, 10'h016, 10'h017, 10'h019};
`else
    localparam logic [9:0] EXP_1C    = 10'h01C;
    localparam logic [9:0] EXP_UPBRK = 10'h375;
    localparam logic [9:0] EXP_76    = 10'h076;
    localparam logic [9:0] EXP_75    = 10'h075;
    localparam logic [9:0] EXP_OVF [9] = '{10'h015, 10'h01D, 10'h024, 10'h02D, 10'h02C,
                                           10'h035, 10'h03C, 10'h043, 10'h04D};
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;
    logic       bat_ok, kbd_err, timeout, overflow, clr;

    int n_checks = 0;
    int n_fails  = 0;

    ps2_key_event_ctrl #(.FIFO_AW(3), .TIMEOUT_CYC(TMO)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .ev_data_o  (ev_data),
        .ev_valid_o (ev_valid),
        .ev_ready_i (ev_ready),
        .bat_ok_o   (bat_ok),
        .kbd_err_o  (kbd_err),
        .timeout_o  (timeout),
        .overflow_o (overflow),
        .clr_i      (clr)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Returns on the falling edge right after the strobe was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] ovf_seq [9]   = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        int tmo_at;
        int n_drained;

        rst_n = 1'b1; rx_data = '0; rx_valid = 1'b0; ev_ready = 1'b0; clr = 1'b0;
        do_reset();
        @(negedge clk);
        chk_val("reset ev_valid", 32'(ev_valid), 32'd0);
        chk_val("reset ev_data", 32'(ev_data), 32'd0);
        chk_val("reset flags", {28'd0, bat_ok, kbd_err, timeout, overflow}, 32'd0);

        // Single make code and its latency
        send_byte(8'h1C);
        chk_val("1C valid at +1", 32'(ev_valid), 32'd0);
        @(negedge clk);
        chk_val("1C valid at +2", 32'(ev_valid), 32'd1);
        chk_val("1C data", 32'(ev_data), 32'(EXP_1C));
        pop_one();
        chk_val("1C popped", 32'(ev_valid), 32'd0);

        // Extended break
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        @(negedge clk);
        chk_val("E0F075 valid", 32'(ev_valid), 32'd1);
        chk_val("E0F075 data", 32'(ev_data), 32'(EXP_UPBRK));
        pop_one();

        // Pause: one event in raw mode, none in keymap mode
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
        @(negedge clk);
`ifdef AMIGA_KEYMAP_EN
        chk_val("pause dropped", 32'(ev_valid), 32'd0);
`else
        chk_val("pause valid", 32'(ev_valid), 32'd1);
        chk_val("pause data", 32'(ev_data), 32'h277);
        pop_one();
        chk_val("pause single", 32'(ev_valid), 32'd0);
`endif

        // Timeout after a lone E0
        send_byte(8'hE0);
        tmo_at = 0;
        for (int i = 1; i <= TMO + 5; i++) begin
            @(negedge clk);
            if (timeout && tmo_at == 0) tmo_at = i;
        end
        chk_val("timeout cycle", 32'(tmo_at), 32'(TMO));
        chk_val("timeout no event", 32'(ev_valid), 32'd0);
        send_byte(8'h76);
        @(negedge clk);
        chk_val("after timeout data", 32'(ev_data), 32'(EXP_76));
        pop_one();

        // Overflow with back-to-back strobes
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rx_data  = ovf_seq[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk_val("ovf flag", 32'(overflow), 32'd1);
        chk_val("ovf head", 32'(ev_data), 32'(EXP_OVF[0]));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk_val("ovf cleared", 32'(overflow), 32'd0);
        // Strobe P, then pop exactly on the cycle the push lands in the full FIFO
        rx_data  = 8'h4D;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        chk_val("push+pop no ovf", 32'(overflow), 32'd0);
        n_drained = 0;
        for (int i = 1; i < 12; i++) begin
            if (!ev_valid) break;
            chk_val($sformatf("drain %0d", i), 32'(ev_data), 32'(EXP_OVF[i < 9 ? i : 8]));
            n_drained++;
            pop_one();
        end
        chk_val("fifo count", 32'(n_drained), 32'd8);

        // Status bytes
        send_byte(8'hAA);
        chk_val("bat_ok set", 32'(bat_ok), 32'd1);
        send_byte(8'hFF);
        chk_val("kbd_err pulse", 32'(kbd_err), 32'd1);
        @(negedge clk);
        chk_val("kbd_err end", 32'(kbd_err), 32'd0);
        send_byte(8'hFA);
        @(negedge clk);
        chk_val("FA dropped", 32'(ev_valid), 32'd0);
        send_byte(8'hFC);
        chk_val("FC kbd_err", 32'(kbd_err), 32'd1);
        chk_val("FC bat_ok clr", 32'(bat_ok), 32'd0);

        // Reset mid-sequence drops the prefix and the queued event
        send_byte(8'h1C);
        send_byte(8'hE0);
        chk_val("pre-reset queued", 32'(ev_valid), 32'd1);
        do_reset();
        chk_val("post-reset empty", 32'(ev_valid), 32'd0);
        send_byte(8'h75);
        @(negedge clk);
        chk_val("post-reset 75", 32'(ev_data), 32'(EXP_75));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
